// File: rtl/flappy_score_ctrl.sv
// Game-state and score controller: counts pipe passes in BCD, tracks the session high score, sequences IDLE/PLAY/DYING/DEAD.
// Latency: every output updates one cycle after the input that causes it (no combinational input-to-output path).
// Backpressure: none; frame_tick/pipe_pass pulses are consumed in the cycle they arrive, presses outside IDLE/DEAD are dropped.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset (clears high score too)
//   frame_tick            one-cycle pulse per video frame (drives DYING length and DEAD display toggling)
//   start_btn             debounced button level; a rising edge is a "press"
//   pipe_pass, collision  events from the pipe/collision logic
//   state                 IDLE=0, PLAY=1, DYING=2, DEAD=3
//   is_dead               high in every state except PLAY
//   score_bcd, high_bcd   packed 3-digit BCD {hundreds, tens, ones}
//   disp_bcd, show_high   digit source for the seg7 stage and which value it is
//   new_high              last finished game beat the stored high score
//   score_inc             one-cycle pulse per accepted (non-saturated) increment
module flappy_score_ctrl #(
    parameter int DEATH_FRAMES = 60,
    parameter int ALT_FRAMES   = 90,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        pipe_pass,
    input  logic        collision,
    output logic [1:0]  state,
    output logic        is_dead,
    output logic [11:0] score_bcd,
    output logic [11:0] high_bcd,
    output logic [11:0] disp_bcd,
    output logic        show_high,
    output logic        new_high,
    output logic        score_inc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    localparam logic [FRAME_CNT_W-1:0] DEATH_LAST = FRAME_CNT_W'(DEATH_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] ALT_LAST   = FRAME_CNT_W'(ALT_FRAMES - 1);
    localparam logic [11:0]            SCORE_MAX  = 12'h999;

    state_t                 state_q, state_d;
    logic [11:0]            score_q, score_d;
    logic [11:0]            high_q, high_d;
    logic                   show_high_q, show_high_d;
    logic                   new_high_q, new_high_d;
    logic                   score_inc_q, score_inc_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   btn_q, btn_d;
    logic                   press;

    // Three-digit BCD increment with ripple carry; never called at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] hund;
        ones = v[3:0];
        tens = v[7:4];
        hund = v[11:8];
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
                hund = hund + 4'd1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {hund, tens, ones};
    endfunction

    // btn_q resets to 1 so a button held through reset is not seen as a press.
    assign press = start_btn & ~btn_q;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        show_high_d = show_high_q;
        new_high_d  = new_high_q;
        score_inc_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        btn_d       = start_btn;

        unique case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d     = S_PLAY;
                    frame_cnt_d = '0;
                end
            end
            S_PLAY: begin
                // Collision wins over a same-cycle pipe_pass; high score is settled here.
                if (collision) begin
                    state_d     = S_DYING;
                    frame_cnt_d = '0;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end else if (pipe_pass && (score_q != SCORE_MAX)) begin
                    score_d     = bcd_inc(score_q);
                    score_inc_d = 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (frame_cnt_q == DEATH_LAST) begin
                        state_d     = S_DEAD;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end
            S_DEAD: begin
                // A press beats a same-cycle frame_tick, so show_high is cleared rather than toggled.
                if (press) begin
                    state_d     = S_IDLE;
                    score_d     = '0;
                    new_high_d  = 1'b0;
                    show_high_d = 1'b0;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    if (frame_cnt_q == ALT_LAST) begin
                        show_high_d = ~show_high_q;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            high_q      <= '0;
            show_high_q <= 1'b0;
            new_high_q  <= 1'b0;
            score_inc_q <= 1'b0;
            frame_cnt_q <= '0;
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            show_high_q <= show_high_d;
            new_high_q  <= new_high_d;
            score_inc_q <= score_inc_d;
            frame_cnt_q <= frame_cnt_d;
            btn_q       <= btn_d;
        end
    end

    assign state     = state_q;
    assign is_dead   = (state_q != S_PLAY);
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign show_high = show_high_q;
    assign new_high  = new_high_q;
    assign score_inc = score_inc_q;
    assign disp_bcd  = show_high_q ? high_q : score_q;

endmodule

// File: doc/flappy_score_ctrl.md
# flappy_score_ctrl

Game-state and score controller for Sneaky Flappy Bird. Sequences the three-digit BCD score: it counts pipe passes only while the game is live, freezes on collision, tracks a session high score, and drives the digit source for the seven-segment stage. It sits between the pipe/collision logic and the seg7 decoders, and provides the `is_dead` level consumed elsewhere in the game.

## Interface

Parameters:
- DEATH_FRAMES, 60, number of `frame_tick` pulses spent in DYING before DEAD.
- ALT_FRAMES, 90, number of `frame_tick` pulses between display toggles (score / high score) in DEAD.
- FRAME_CNT_W, 8, width of the internal frame counter; must hold max(DEATH_FRAMES, ALT_FRAMES).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state including high score.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_btn  in  1  debounced level from the flap/start button.
- pipe_pass  in  1  one-cycle pulse when the bird clears a pipe.
- collision  in  1  level or pulse; bird hit pipe/ground.
- state  out  2  IDLE=0, PLAY=1, DYING=2, DEAD=3.
- is_dead  out  1  high in every state except PLAY.
- score_bcd  out  12  current score, packed BCD {hundreds, tens, ones}.
- high_bcd  out  12  session high score, packed BCD.
- disp_bcd  out  12  value the seg7 stage shows.
- show_high  out  1  1 when disp_bcd is high_bcd.
- new_high  out  1  the last game set a new high score.
- score_inc  out  1  one-cycle pulse on each accepted increment.

## Operation

- Button edge: press = start_btn & ~btn_q; btn_q resets to 1, so a button held through reset does not produce a press.
- IDLE: score_bcd = 0. A press moves to PLAY; the frame counter is cleared.
- PLAY: pipe_pass increments score_bcd and pulses score_inc. A collision moves to DYING. If collision and pipe_pass are both high in the same cycle, collision wins and no increment occurs. A press in PLAY is ignored.
- BCD increment:
  - Ones digit 9 rolls to 0 and carries into tens; tens carries the same way into hundreds.
  - At 999 the score saturates; pipe_pass is still accepted but score_bcd stays 999 and score_inc does not pulse.
  - Digits never hold A–F.
- High score, evaluated on the PLAY→DYING cycle:
  - If score_bcd > high_bcd (a packed 12-bit unsigned compare is valid for BCD), high_bcd takes score_bcd and new_high is set.
  - Equal scores do not update high_bcd.
- DYING: everything is frozen. The frame counter counts frame_tick pulses; on reaching DEATH_FRAMES the block moves to DEAD and the counter clears. Presses are ignored.
- DEAD: show_high toggles every ALT_FRAMES frame ticks, starting at 0. A press moves to IDLE, which clears score_bcd, new_high, show_high and the frame counter. high_bcd is retained.
- disp_bcd = show_high ? high_bcd : score_bcd. show_high is 0 in every state except DEAD.
- reset, at any time and in any state:
  - state=IDLE, score_bcd=0, high_bcd=0, new_high=0, show_high=0, score_inc=0, frame counter=0, btn_q=1.
  - is_dead=1, disp_bcd=0.

## Timing

- All outputs are registered or derived from registered state. There is no combinational input-to-output path.
- pipe_pass at cycle N: score_bcd and score_inc update at N+1.
- collision at N: state=DYING and is_dead=1 at N+1. high_bcd and new_high also update at N+1.
- Press edge at N: state change visible at N+1.
- DYING lasts exactly DEATH_FRAMES frame_tick pulses, counted after entry. A frame_tick in the entry cycle is not counted.
- If frame_tick and a press arrive in the same cycle in DEAD, the press wins and show_high is 0 at N+1.
- Reset has priority over every other input.

## Test plan

- Reset with start_btn held high, then release and press: no PLAY until the second rising edge. All outputs read 0, with is_dead=1 and state=0.
- Press, then 19 pipe_pass pulses: score_bcd=0x019. The 10th pulse shows the carry 0x009→0x010; score_inc pulses 19 times.
- Preload via 999 pulses, then 3 more: score_bcd stays 0x999 and score_inc does not pulse after the 999th.
- Collision and pipe_pass in the same cycle at score 0x042: score stays 0x042, state=DYING next cycle, high_bcd=0x042, new_high=1.
- Second game ending at 0x042, equal to the stored high: high_bcd unchanged, new_high=0. Third game ending at 0x043: high_bcd=0x043.
- With DEATH_FRAMES=2 and ALT_FRAMES=3: DEAD is entered after the 2nd tick. show_high is 1 after 3 ticks and 0 after 6. A press in DEAD gives IDLE, score=0, high retained. Reset asserted mid-PLAY clears everything within one cycle.
